// File: rtl/sha3_axis_padder.sv
// ---------------------------------------------------------------------------
// sha3_axis_padder
//
// Front end of the AXI SHA-3 engine. Accepts a byte-granular AXI-Stream
// message, packs it into rate-sized blocks, applies SHA-3 domain padding
// (0x06 ... 0x80) and hands each block to the Keccak absorb core over a
// valid/ready handshake. The SHA-3 variant is chosen per message from tuser
// on the first beat.
//
// Ports:
//   ACLK, ARESETn   clock, asynchronous active-low reset
//   s_axis_tdata    message beat, first byte in the top lane
//   s_axis_tkeep    byte enables, MSB belongs to the first byte
//   s_axis_tuser    mode 0..3 = SHA3-224/256/384/512 (first beat only)
//   s_axis_tlast    final beat of the message
//   s_axis_tvalid   beat valid
//   s_axis_tready   beat accepted when tvalid & tready
//   blk_data        rate block, message byte k at [8k+7:8k], zero above R
//   blk_mode        mode latched for the current message
//   blk_last        block is the final (padded) block of the message
//   blk_valid       block valid
//   blk_ready       absorb core accepts the block
//   err_keep        sticky flag for illegal tkeep patterns
// ---------------------------------------------------------------------------
module sha3_axis_padder #(
  parameter int WIDTH    = 16,
  parameter int RATE_MAX = 1152
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic [WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [1:0]           s_axis_tuser,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [RATE_MAX-1:0]  blk_data,
  output logic [1:0]           blk_mode,
  output logic                 blk_last,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 err_keep
);

  localparam int NB = WIDTH / 8;                     // bytes per beat
  localparam int RB = RATE_MAX / 8;                  // bytes per block buffer
  localparam int CW = $clog2(RB + 1);                // byte counter width
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;     // lane index width
  localparam logic [NB-1:0] KEEP_ALL = '1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } state_t;

  // Rate in bytes for each SHA-3 variant.
  function automatic logic [CW-1:0] rate_of(input logic [1:0] m);
    logic [CW-1:0] r;
    case (m)
      2'd0:    r = CW'(144);
      2'd1:    r = CW'(136);
      2'd2:    r = CW'(104);
      default: r = CW'(72);
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t         state_reg;
  logic [CW-1:0]  byte_cnt_reg;
  logic [1:0]     mode_reg;
  logic           new_msg_reg;
  logic           pad_pending_reg;
  logic           tready_reg;
  logic           blk_valid_reg;
  logic           blk_last_reg;
  logic           err_keep_reg;

  // -------------------------------------------------------------------------
  // Beat decode
  // -------------------------------------------------------------------------
  logic [LW:0]    keep_cnt;
  logic [NB-1:0]  keep_mask;
  logic           beat_err;
  logic [CW-1:0]  beat_len;
  logic [1:0]     cur_mode;
  logic [CW-1:0]  cur_rate;
  logic [CW-1:0]  cur_last_pos;
  logic [CW-1:0]  emit_last_pos;
  logic [CW-1:0]  fill_sum;
  logic           beat_fire;
  logic           blk_fire;
  logic           blk_full;
  logic           pad_now;
  logic           buf_clear;
  logic           buf_extra;

  logic [7:0]     beat_byte [NB];
  logic [NB-1:0]  beat_keep;

  always_comb begin
    keep_cnt = '0;
    for (int j = 0; j < NB; j++) begin
      keep_cnt = keep_cnt + (LW+1)'(s_axis_tkeep[j]);
    end
  end

  // A legal tkeep is a run of ones starting at the first byte lane. Anything
  // else, or a short beat that is not the last one, flags an error; such a
  // beat is then taken whole so the byte count stays beat-aligned.
  assign keep_mask = ~(KEEP_ALL >> keep_cnt);
  assign beat_err  = (s_axis_tkeep != keep_mask) ||
                     (!s_axis_tlast && (s_axis_tkeep != KEEP_ALL));
  assign beat_len  = beat_err ? CW'(NB) : CW'(keep_cnt);

  // The mode is taken from tuser only on the first beat of a message, and
  // must be known on that same beat to size the block.
  assign cur_mode      = new_msg_reg ? s_axis_tuser : mode_reg;
  assign cur_rate      = rate_of(cur_mode);
  assign cur_last_pos  = cur_rate - CW'(1);
  assign emit_last_pos = rate_of(mode_reg) - CW'(1);

  assign beat_fire = s_axis_tvalid && tready_reg;
  assign blk_fire  = blk_valid_reg && blk_ready;
  assign fill_sum  = byte_cnt_reg + beat_len;
  assign blk_full  = (fill_sum == cur_rate);
  assign pad_now   = beat_fire && s_axis_tlast && !blk_full;

  assign buf_clear = (state_reg == EMIT) && blk_fire && !pad_pending_reg;
  assign buf_extra = (state_reg == EXTRA);

  genvar gi;

  // Lane j of the beat is message byte j of this beat (big-endian lanes).
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign beat_byte[gi] = s_axis_tdata[WIDTH-1-8*gi -: 8];
      assign beat_keep[gi] = beat_err || s_axis_tkeep[NB-1-gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Block buffer: one register per byte. Each byte picks its beat lane by
  // its distance from byte_cnt, then ORs in padding when the final beat
  // lands short of the rate.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < RB; gi++) begin : g_byte
      localparam logic [CW-1:0] POS = CW'(gi);

      logic [7:0]    byte_reg;
      logic [7:0]    byte_next;
      logic [CW-1:0] offset;
      logic          in_win;

      always_comb begin
        offset    = POS - byte_cnt_reg;
        in_win    = (POS >= byte_cnt_reg) && (offset < CW'(NB));
        byte_next = byte_reg;
        if (in_win && beat_keep[offset[LW-1:0]]) begin
          byte_next = beat_byte[offset[LW-1:0]];
        end
        // Both pad bytes may hit the same position, giving 0x86.
        if (pad_now && (POS == fill_sum)) begin
          byte_next = byte_next | 8'h06;
        end
        if (pad_now && (POS == cur_last_pos)) begin
          byte_next = byte_next | 8'h80;
        end
      end

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          byte_reg <= 8'h00;
        end else if (buf_clear) begin
          byte_reg <= 8'h00;
        end else if (buf_extra) begin
          // Pad-only block that follows a message ending exactly on a block.
          if (POS == '0) begin
            byte_reg <= 8'h06;
          end else if (POS == emit_last_pos) begin
            byte_reg <= 8'h80;
          end else begin
            byte_reg <= 8'h00;
          end
        end else if (beat_fire) begin
          byte_reg <= byte_next;
        end
      end

      assign blk_data[8*gi +: 8] = byte_reg;
    end

    if (RATE_MAX > 8 * RB) begin : g_tail
      assign blk_data[RATE_MAX-1:8*RB] = '0;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg       <= FILL;
      byte_cnt_reg    <= '0;
      mode_reg        <= 2'd0;
      new_msg_reg     <= 1'b1;
      pad_pending_reg <= 1'b0;
      tready_reg      <= 1'b0;
      blk_valid_reg   <= 1'b0;
      blk_last_reg    <= 1'b0;
      err_keep_reg    <= 1'b0;
    end else begin
      if (beat_fire && beat_err) begin
        err_keep_reg <= 1'b1;
      end

      case (state_reg)
        FILL: begin
          tready_reg <= 1'b1;
          if (beat_fire) begin
            byte_cnt_reg <= fill_sum;
            mode_reg     <= cur_mode;
            new_msg_reg  <= 1'b0;
            if (blk_full || s_axis_tlast) begin
              state_reg       <= EMIT;
              tready_reg      <= 1'b0;
              blk_valid_reg   <= 1'b1;
              // A message ending exactly on the rate still needs its own
              // pad block, so this one is not the last.
              blk_last_reg    <= s_axis_tlast && !blk_full;
              pad_pending_reg <= s_axis_tlast && blk_full;
            end
          end
        end

        EMIT: begin
          if (blk_fire) begin
            blk_valid_reg <= 1'b0;
            if (pad_pending_reg) begin
              state_reg <= EXTRA;
            end else begin
              state_reg    <= FILL;
              tready_reg   <= 1'b1;
              byte_cnt_reg <= '0;
              new_msg_reg  <= new_msg_reg || blk_last_reg;
              blk_last_reg <= 1'b0;
            end
          end
        end

        EXTRA: begin
          state_reg       <= EMIT;
          blk_valid_reg   <= 1'b1;
          blk_last_reg    <= 1'b1;
          pad_pending_reg <= 1'b0;
        end

        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_reg;
  assign blk_mode      = mode_reg;
  assign blk_last      = blk_last_reg;
  assign blk_valid     = blk_valid_reg;
  assign err_keep      = err_keep_reg;

endmodule

// File: tb/tb_sha3_axis_padder.sv
// ---------------------------------------------------------------------------
// tb_sha3_axis_padder
//
// Self-checking bench for sha3_axis_padder (WIDTH=16). Messages are built as
// byte queues; the expected blocks come from the plain SHA-3 rule: append
// 0x06, zero-fill to a multiple of the rate, OR 0x80 into the final byte and
// cut into rate-sized blocks.
// ---------------------------------------------------------------------------
module tb_sha3_axis_padder;

  localparam int WIDTH    = 16;
  localparam int RATE_MAX = 1152;
  localparam int RB       = RATE_MAX / 8;

  logic                ACLK = 1'b0;
  logic                ARESETn = 1'b0;
  logic [WIDTH-1:0]    s_axis_tdata = '0;
  logic [WIDTH/8-1:0]  s_axis_tkeep = '0;
  logic [1:0]          s_axis_tuser = '0;
  logic                s_axis_tlast = 1'b0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tready;
  logic [RATE_MAX-1:0] blk_data;
  logic [1:0]          blk_mode;
  logic                blk_last;
  logic                blk_valid;
  logic                blk_ready = 1'b0;
  logic                err_keep;

  sha3_axis_padder #(.WIDTH(WIDTH), .RATE_MAX(RATE_MAX)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .blk_data      (blk_data),
    .blk_mode      (blk_mode),
    .blk_last      (blk_last),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .err_keep      (err_keep)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  logic [RATE_MAX-1:0] got_data [$];
  logic [1:0]          got_mode [$];
  logic                got_last [$];
  logic [RATE_MAX-1:0] exp_data [$];
  logic                exp_last [$];
  logic [7:0]          tx_bytes [$];
  logic [1:0]          tx_mode;
  bit                  tx_empty_tail = 0;
  bit                  rand_ready = 0;

  // Block monitor: values sampled at the negedge hold through the next
  // posedge, where the handshake happens.
  initial forever begin
    @(negedge ACLK);
    if (ARESETn && blk_valid && blk_ready) begin
      got_data.push_back(blk_data);
      got_mode.push_back(blk_mode);
      got_last.push_back(blk_last);
    end
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge ACLK);
    #1;
    if (rand_ready) blk_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic int rate_of(input logic [1:0] m);
    case (m)
      2'd0: return 144;
      2'd1: return 136;
      2'd2: return 104;
      default: return 72;
    endcase
  endfunction

  function automatic int first_diff(input logic [RATE_MAX-1:0] a, input logic [RATE_MAX-1:0] b);
    for (int i = 0; i < RB; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
    return 0;
  endfunction

  // Reference model: SHA-3 padding of the whole message, then split.
  task automatic build_expected();
    logic [7:0] p [$];
    int r;
    int nblk;
    logic [RATE_MAX-1:0] v;
    r = rate_of(tx_mode);
    exp_data.delete();
    exp_last.delete();
    p = tx_bytes;
    p.push_back(8'h06);
    while (p.size() % r != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / r;
    for (int b = 0; b < nblk; b++) begin
      v = '0;
      for (int i = 0; i < r; i++) v[8*i +: 8] = p[b*r + i];
      exp_data.push_back(v);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive_beat(input logic [15:0] d, input logic [1:0] k, input logic l,
                            input logic [1:0] u, output bit ok);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge ACLK);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge ACLK);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_msg(output bit ok);
    int n;
    int i;
    bit b_ok;
    logic [15:0] rnd;
    logic [15:0] d;
    logic [1:0] k;
    logic [1:0] u;
    n = tx_bytes.size();
    i = 0;
    ok = 1;
    while (i < n) begin
      rnd = 16'($urandom);
      if (n - i >= 2) begin
        d = {tx_bytes[i], tx_bytes[i+1]};
        k = 2'b11;
      end else begin
        d = {tx_bytes[i], rnd[7:0]};
        k = 2'b10;
      end
      u = (i == 0) ? tx_mode : 2'($urandom);
      drive_beat(d, k, (n - i <= 2) && !tx_empty_tail, u, b_ok);
      ok = ok && b_ok;
      i += 2;
    end
    if (n == 0 || tx_empty_tail) begin
      rnd = 16'($urandom);
      u = (n == 0) ? tx_mode : 2'($urandom);
      drive_beat(rnd, 2'b00, 1'b1, u, b_ok);
      ok = ok && b_ok;
    end
    $display("msg mode=%0d len=%0d empty_tail=%0b blocks=%0d", tx_mode, n, tx_empty_tail, exp_data.size());
  endtask

  // Waits for n captured blocks; returns at posedge+1.
  task automatic wait_blocks(input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      if (got_data.size() >= n) begin
        ok = 1;
        break;
      end
      @(negedge ACLK);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic new_msg(input logic [1:0] m);
    tx_mode = m;
    tx_empty_tail = 0;
    tx_bytes.delete();
    got_data.delete();
    got_mode.delete();
    got_last.delete();
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if (s_axis_tready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0 ||
        blk_mode !== 2'd0 || err_keep !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got tready=%b valid=%b last=%b mode=%0d err=%b want all 0",
               s_axis_tready, blk_valid, blk_last, blk_mode, err_keep);
    end
    checks++;
    if (blk_data !== '0) begin
      failures++;
      $display("FAIL reset_data got nonzero byte %0d want 0", first_diff(blk_data, '0));
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_abc_mode1();
    bit ok;
    bit w;
    new_msg(2'd1);
    tx_bytes = '{8'h61, 8'h62, 8'h63};
    build_expected();
    blk_ready = 1'b1;
    send_msg(ok);
    wait_blocks(exp_data.size(), w);
    checks++;
    if (!ok || !w) begin
      failures++;
      $display("FAIL abc_timeout got %0d blocks want %0d", got_data.size(), exp_data.size());
    end else begin
      checks++;
      if (got_data[0][31:0] !== 32'h06636261 || got_data[0][135*8 +: 8] !== 8'h80 ||
          got_last[0] !== 1'b1 || got_mode[0] !== 2'd1) begin
        failures++;
        $display("FAIL abc_bytes got b0..3=%h b135=%h last=%b mode=%0d want 06636261 80 1 1",
                 got_data[0][31:0], got_data[0][135*8 +: 8], got_last[0], got_mode[0]);
      end
      checks++;
      if (got_data.size() != 1 || got_data[0] !== exp_data[0]) begin
        failures++;
        $display("FAIL abc_block got %0d blocks, diff at byte %0d want 1 block",
                 got_data.size(), first_diff(got_data[0], exp_data[0]));
      end
    end
  endtask

  task automatic test_empty_mode3();
    bit ok;
    bit w;
    new_msg(2'd3);
    build_expected();
    send_msg(ok);
    wait_blocks(1, w);
    checks++;
    if (!ok || !w) begin
      failures++;
      $display("FAIL empty_timeout got %0d blocks want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0][7:0] !== 8'h06 || got_data[0][71*8 +: 8] !== 8'h80 ||
          got_data[0][RATE_MAX-1:72*8] !== '0 || got_last[0] !== 1'b1 || got_mode[0] !== 2'd3) begin
        failures++;
        $display("FAIL empty_block got b0=%h b71=%h last=%b mode=%0d want 06 80 1 3",
                 got_data[0][7:0], got_data[0][71*8 +: 8], got_last[0], got_mode[0]);
      end
      checks++;
      if (got_data[0] !== exp_data[0]) begin
        failures++;
        $display("FAIL empty_model diff at byte %0d got %h want %h", first_diff(got_data[0], exp_data[0]),
                 got_data[0][8*first_diff(got_data[0], exp_data[0]) +: 8],
                 exp_data[0][8*first_diff(got_data[0], exp_data[0]) +: 8]);
      end
    end
  endtask

  task automatic test_len135();
    bit ok;
    bit w;
    new_msg(2'd1);
    for (int i = 0; i < 135; i++) tx_bytes.push_back(8'($urandom));
    build_expected();
    send_msg(ok);
    wait_blocks(1, w);
    checks++;
    if (!ok || !w) begin
      failures++;
      $display("FAIL len135_timeout got %0d blocks want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0][135*8 +: 8] !== 8'h86 || got_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL len135_pad got b135=%h last=%b want 86 1", got_data[0][135*8 +: 8], got_last[0]);
      end
      checks++;
      if (got_data.size() != 1 || got_data[0] !== exp_data[0]) begin
        failures++;
        $display("FAIL len135_model got %0d blocks diff byte %0d want 1", got_data.size(),
                 first_diff(got_data[0], exp_data[0]));
      end
    end
  endtask

  task automatic test_boundary_136();
    bit ok;
    bit w;
    new_msg(2'd1);
    for (int i = 0; i < 136; i++) tx_bytes.push_back(8'($urandom));
    build_expected();
    send_msg(ok);
    // Expected per-cycle view from the accepting edge onward:
    // block1 offered, EXTRA gap, pad block offered, back to FILL.
    @(negedge ACLK);
    checks++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b0 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL b136_blk1 got valid=%b last=%b tready=%b want 1 0 0", blk_valid, blk_last, s_axis_tready);
    end
    @(negedge ACLK);
    checks++;
    if (blk_valid !== 1'b0 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL b136_extra got valid=%b tready=%b want 0 0", blk_valid, s_axis_tready);
    end
    @(negedge ACLK);
    checks++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL b136_blk2 got valid=%b last=%b tready=%b want 1 1 0", blk_valid, blk_last, s_axis_tready);
    end
    @(negedge ACLK);
    checks++;
    if (blk_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL b136_fill got valid=%b tready=%b want 0 1", blk_valid, s_axis_tready);
    end
    wait_blocks(2, w);
    checks++;
    if (!ok || !w || got_data.size() != 2) begin
      failures++;
      $display("FAIL b136_count got %0d blocks want 2", got_data.size());
    end else begin
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (got_data[b] !== exp_data[b] || got_last[b] !== exp_last[b] || got_mode[b] !== 2'd1) begin
          failures++;
          $display("FAIL b136_blk%0d last=%b/%b mode=%0d diff byte %0d", b, got_last[b], exp_last[b],
                   got_mode[b], first_diff(got_data[b], exp_data[b]));
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit w;
    bit stable;
    logic [RATE_MAX-1:0] snap;
    new_msg(2'd0);
    for (int i = 0; i < 9; i++) tx_bytes.push_back(8'($urandom));
    build_expected();
    blk_ready = 1'b0;
    send_msg(ok);
    checks++;
    if (!ok || blk_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_latency got valid=%b want 1 on cycle after last beat", blk_valid);
    end
    snap = blk_data;
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      if (blk_valid !== 1'b1 || blk_data !== snap || s_axis_tready !== 1'b0 || blk_last !== 1'b1)
        stable = 0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL stall_hold got valid=%b tready=%b last=%b data_changed=%b want 1 0 1 0",
               blk_valid, s_axis_tready, blk_last, blk_data !== snap);
    end
    @(posedge ACLK);
    #1;
    blk_ready = 1'b1;
    @(posedge ACLK);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1 || blk_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got tready=%b valid=%b want 1 0", s_axis_tready, blk_valid);
    end
    wait_blocks(1, w);
    checks++;
    if (!w || got_data.size() != 1 || got_data[0] !== exp_data[0] || got_mode[0] !== 2'd0) begin
      failures++;
      $display("FAIL stall_block got %0d blocks mode=%0d want 1 block mode 0", got_data.size(),
               (got_mode.size() > 0) ? got_mode[0] : 2'd0);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit w;
    int n;
    int r;
    int sel;
    rand_ready = 1;
    for (int m = 0; m < 24; m++) begin
      new_msg(2'($urandom));
      r = rate_of(tx_mode);
      sel = $urandom_range(0, 5);
      case (sel)
        0: n = r - 1;
        1: n = r;
        2: n = 2 * r;
        3: n = r + 1;
        default: n = $urandom_range(0, 300);
      endcase
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
      tx_empty_tail = (n % 2 == 0) && ($urandom_range(0, 2) == 0);
      build_expected();
      send_msg(ok);
      wait_blocks(exp_data.size(), w);
      repeat (4) @(posedge ACLK);
      #1;
      checks++;
      if (!ok || !w || got_data.size() != exp_data.size()) begin
        failures++;
        $display("FAIL rand%0d_count got %0d blocks want %0d (len %0d mode %0d)", m, got_data.size(),
                 exp_data.size(), n, tx_mode);
      end else begin
        for (int b = 0; b < exp_data.size(); b++) begin
          checks++;
          if (got_data[b] !== exp_data[b] || got_last[b] !== exp_last[b] || got_mode[b] !== tx_mode) begin
            failures++;
            $display("FAIL rand%0d_blk%0d last=%b/%b mode=%0d/%0d byte%0d got=%h want=%h", m, b,
                     got_last[b], exp_last[b], got_mode[b], tx_mode, first_diff(got_data[b], exp_data[b]),
                     got_data[b][8*first_diff(got_data[b], exp_data[b]) +: 8],
                     exp_data[b][8*first_diff(got_data[b], exp_data[b]) +: 8]);
          end
        end
      end
    end
    rand_ready = 0;
    @(posedge ACLK);
    #1;
    blk_ready = 1'b1;
    checks++;
    if (err_keep !== 1'b0) begin
      failures++;
      $display("FAIL rand_err_keep got %b want 0 for legal traffic", err_keep);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit w;
    for (int i = 0; i < 5; i++) begin
      drive_beat(16'($urandom), 2'b11, 1'b0, 2'd0, ok);
    end
    ARESETn = 1'b0;
    #2;
    checks++;
    if (s_axis_tready !== 1'b0 || blk_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got tready=%b valid=%b want 0 0", s_axis_tready, blk_valid);
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    new_msg(2'd2);
    tx_bytes = '{8'h61, 8'h62, 8'h63};
    build_expected();
    send_msg(ok);
    wait_blocks(1, w);
    checks++;
    if (!ok || !w || got_data.size() != 1 || got_data[0] !== exp_data[0] ||
        got_data[0][103*8 +: 8] !== 8'h80 || got_mode[0] !== 2'd2 || got_last[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_abc got %0d blocks diff byte %0d want clean abc block mode 2", got_data.size(),
               (got_data.size() > 0) ? first_diff(got_data[0], exp_data[0]) : 0);
    end
  endtask

  task automatic test_err_keep();
    bit ok;
    bit w;
    new_msg(2'd0);
    // A short non-last beat is taken whole: both bytes land in the block.
    tx_bytes = '{8'h41, 8'h42, 8'h43, 8'h44};
    build_expected();
    checks++;
    if (err_keep !== 1'b0) begin
      failures++;
      $display("FAIL err_start got %b want 0", err_keep);
    end
    drive_beat(16'h4142, 2'b10, 1'b0, 2'd0, ok);
    checks++;
    if (!ok || err_keep !== 1'b1) begin
      failures++;
      $display("FAIL err_set got %b want 1", err_keep);
    end
    drive_beat(16'h4344, 2'b11, 1'b1, 2'd3, ok);
    wait_blocks(1, w);
    checks++;
    if (!ok || !w || got_data.size() != 1 || got_data[0] !== exp_data[0] || got_mode[0] !== 2'd0) begin
      failures++;
      $display("FAIL err_block got %0d blocks b0..3=%h want 1 block b0..3=44434241", got_data.size(),
               (got_data.size() > 0) ? got_data[0][31:0] : 32'h0);
    end
    checks++;
    if (err_keep !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %b want 1", err_keep);
    end
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    checks++;
    if (err_keep !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got %b want 0", err_keep);
    end
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_abc_mode1();
    test_empty_mode3();
    test_len135();
    test_boundary_136();
    test_stall();
    test_random();
    test_reset_mid();
    test_err_keep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha3_axis_padder.md
Name: sha3_axis_padder

Overview:
- Front end of the AXI SHA-3 engine: accepts a byte-granular AXI-Stream message and packs it into rate-sized blocks.
- Applies FIPS-202 SHA-3 padding (0x06 … 0x80) and hands complete blocks to the Keccak absorb core over a valid/ready handshake.
- Successor to the fixed 16-bit, full-word input path:
  - data width is parametrised;
  - partial final beats are supported via TKEEP;
  - SHA-3 mode is selected per message at run time.

Parameters:
- WIDTH, 16, stream data width in bits. Legal values: 8, 16, 32, 64. Every rate is a multiple of WIDTH/8.
- RATE_MAX, 1152, output block width in bits. Equals the SHA3-224 rate.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- s_axis_tdata  in  WIDTH  message beat; first message byte in [WIDTH-1:WIDTH-8]
- s_axis_tkeep  in  WIDTH/8  byte enables; bit WIDTH/8-1 maps to the first byte
- s_axis_tuser  in  2  mode: 0=224, 1=256, 2=384, 3=512; sampled on the first beat of a message
- s_axis_tlast  in  1  final beat of the message
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid & tready
- blk_data  out  RATE_MAX  block; message byte k at [8k+7:8k]; bytes at or above R are zero
- blk_mode  out  2  mode latched for the current message
- blk_last  out  1  block is the final (padded) block of the message
- blk_valid  out  1  block valid
- blk_ready  in  1  core accepts the block when blk_valid & blk_ready
- err_keep  out  1  sticky; set by a non-last beat with tkeep not all ones, or by non-contiguous tkeep

Behaviour:
- Reset values:
  - all outputs 0, except s_axis_tready, which is 1 once reset is released;
  - buffer cleared, byte_cnt=0, mode=0, state FILL.
- Rate R in bytes by mode: 144 / 136 / 104 / 72.
- States:
  - FILL: tready=1, blk_valid=0.
  - EMIT: tready=0, blk_valid=1.
  - EXTRA: tready=0, blk_valid=0, lasts one cycle.
- FILL, accepted beat, with k = popcount(tkeep):
  - writes the kept bytes at byte_cnt upward, then byte_cnt += k;
  - on the first beat of a message (new_msg flag set), latches mode from tuser before computing R.
- Transitions from FILL after an accepted beat:
  - No tlast, byte_cnt+k == R: go to EMIT, blk_last=0, message continues.
  - tlast, byte_cnt+k < R: pad in place, buf[n] |= 0x06 and buf[R-1] |= 0x80 with n = byte_cnt+k. If n == R-1, that byte becomes 0x86. Go to EMIT, blk_last=1.
  - tlast, byte_cnt+k == R: go to EMIT with blk_last=0 and pad_pending=1.
- Empty message (tlast with tkeep=0, on the first or a boundary beat): a pad-only block is produced, byte0=0x06 and byte R-1=0x80.
- EMIT, handshake:
  - pad_pending=1: go to EXTRA;
  - otherwise: go to FILL, clear the buffer and byte_cnt; set new_msg if blk_last was 1.
- EXTRA: buffer = byte0 0x06, byte R-1 0x80; go to EMIT with blk_last=1 and pad_pending=0.
- Handshake rules:
  - while blk_valid=1 and blk_ready=0, blk_data, blk_mode and blk_last are held stable;
  - blk_valid deasserts only after a handshake.
- Latency:
  - blk_valid rises on the cycle after the accepting beat;
  - after a handshake, tready is back at 1 on the next cycle (on the third cycle via EXTRA).
- A beat never crosses a block boundary, because only the final beat may be partial.
- Erroneous beats (err_keep set): the beat is counted as WIDTH/8 bytes and all its data is written.
- tuser changes mid-message are ignored.
- ARESETn low at any time: the partial message is discarded and the block returns to reset values; err_keep is cleared only by reset.

Test Plan:
- WIDTH=16, mode 1, beats 0x6162 (keep 11), 0x6300 (keep 10, last) -> one block: bytes 0..3 = 61 62 63 06, byte135=0x80, rest 0, blk_last=1, blk_mode=1.
- Mode 3, a single beat with tlast and keep 00 -> byte0=0x06, byte71=0x80, bytes at or above 72 zero, blk_last=1.
- Mode 1, 136 bytes (68 full beats) -> block 1 with blk_last=0 and message data; then after one EXTRA cycle, block 2 with byte0=0x06, byte135=0x80, blk_last=1; tready=0 throughout.
- Mode 1, 135 bytes -> one block, byte135=0x86, blk_last=1.
- blk_ready held low for 10 cycles -> blk_valid stays 1, blk_data stable, tready=0; handshake on cycle 11, tready=1 on the next cycle.
- ARESETn pulsed mid-message, followed by the "abc" message with mode 2 -> the output matches the "abc" vector with byte103=0x80; there is no residue of the discarded message.
